rv32i_cpu: RTL and testbench
============================

# rv32i_cpu

Single-cycle RV32I integer core, instantiated as `cpu`, that fetches, decodes, executes and retires one instruction per clock. It contains three submodule instances:
- an instruction memory, instance `instr_mem`, with word array `mem`;
- a 32×32 register file, instance `reg_file`, with array `regs[0:31]`;
- a data memory.

Benches preload programs through hierarchical writes to `instr_mem.mem[]` and check results by reading `reg_file.regs[]`. The core has no functional outputs.

## Interface
- IMEM_WORDS, 256, instruction memory depth in 32-bit words
- DMEM_WORDS, 256, data memory depth in 32-bit words
- clk  input  1  sole clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)

## Operation
- PC: 32-bit register.
  - Fetch word is `instr_mem.mem[pc[31:2] % IMEM_WORDS]`; the fetch path is combinational.
  - Next PC is pc+4 unless a taken branch or jump redirects it.
- Supported instructions; all arithmetic is 32-bit modulo 2^32 with no overflow traps:
  - R-type: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - I-type ALU: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - LUI, AUIPC.
  - JAL, JALR. JALR computes (rs1+imm) & ~1, and writes link pc+4.
  - Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
- Immediates are sign-extended per RV32I I/S/B/U/J formats. Shift amount is the low 5 bits of rs2 or imm.
- Branch/jump targets have bits [1:0] forced to 0.
- Register file:
  - Two combinational read ports and one synchronous write port.
  - x0 reads 0; writes to x0 are discarded.
  - Reading a register written in the same cycle returns the old value.
- Any unrecognised opcode/funct combination executes as a NOP: pc+4, no register or memory write.
- Reset (reset=0):
  - pc ← 0 and all `regs` ← 0, immediately and asynchronously.
  - `instr_mem.mem` and data memory contents are preserved.
- Memories are not reset; instruction memory is never written by the core.

## Timing
- CPI = 1. The instruction at pc is fully committed at the rising edge: rd write, memory write and pc update occur on the same edge.
- First rising edge with reset=1 executes `mem[0]`; the Nth such edge retires the Nth instruction of straight-line code.
- Back-to-back dependences need no stall or bypass, because each result is written before the next instruction reads.
- Reset asserted mid-operation:
  - The in-flight instruction is abandoned with no partial writes.
  - State stays cleared while reset=0.
  - Execution restarts at address 0 on the first rising edge after release.
- PC wrap: fetch index wraps modulo IMEM_WORDS. Data address index is addr[31:2] % DMEM_WORDS; addr[1:0] are ignored.
- Uninitialised instruction words propagate X. Benches must initialise every word executed.

## Configuration
- CPU_DMEM_EN:
  - Defined: data memory is instantiated. LW reads the word combinationally and writes rd on the edge; SW writes the word on the edge.
  - Undefined: no data memory exists. LW and SW execute as NOPs (pc+4, no writes), and DMEM_WORDS is unused.

## Test plan
- Load mem[0..2] = 00100093, 00200113, 002081b3 (addi x1,x0,1; addi x2,x0,2; add x3,x1,x2). Release reset and wait 10 cycles -> regs[1]=1, regs[2]=2, regs[3]=3.
- addi x1,x0,-1; srli x2,x1,4; srai x3,x1,4; sltu x4,x0,x1 -> x2=0FFFFFFF, x3=FFFFFFFF, x4=1.
- addi x0,x0,5 followed by add x5,x0,x0 -> regs[0]=0, regs[5]=0.
- Branch/jump: addi x1,x0,3; bne x1,x0,+8; addi x2,x0,9 (skipped); jal x6,+8 -> x2=0, x6=0x10, and execution continues at 0x14.
- With CPU_DMEM_EN: lui x1,0x12345; sw x1,8(x0); lw x7,8(x0) -> x7=12345000. Without CPU_DMEM_EN -> x7=0.
- Run the first program, assert reset for one cycle mid-run, then release -> all regs return to 0, the program re-executes from pc=0, and the final x3=3.

Source files
------------

// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core: combinational fetch/decode/execute, commit on the rising edge.
// Define CPU_DMEM_EN to build the data memory; without it LW/SW retire as NOPs.

module rv32i_imem #(
  parameter int unsigned Words = 256,
  parameter int unsigned Aw    = 8
) (
  input  logic [Aw-1:0] addr_i,
  output logic [31:0]   rdata_o
);
  // Loaded from outside the core; never written by it.
  logic [31:0] mem [0:Words-1];

  assign rdata_o = mem[addr_i];
endmodule

module rv32i_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs[raddr_b_i];
endmodule

`ifdef CPU_DMEM_EN
module rv32i_dmem #(
  parameter int unsigned Words = 256,
  parameter int unsigned Aw    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem [0:Words-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];
endmodule
`endif

module rv32i_cpu #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  localparam int unsigned ImemAw = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra, AluSlt, AluSltu
  } alu_op_e;
  typedef enum logic [1:0] {ASelRs1, ASelPc, ASelZero} a_sel_e;
  typedef enum logic [1:0] {WbAlu, WbPc4, WbLoad} wb_sel_e;
  typedef enum logic [1:0] {PcSeq, PcBranch, PcJal, PcJalr} pc_sel_e;

  // Shared funct3 map for OP and OP-IMM; alt selects SUB/SRA.
  function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? AluSub : AluAdd;
      3'b001:  f3_op = AluSll;
      3'b010:  f3_op = AluSlt;
      3'b011:  f3_op = AluSltu;
      3'b100:  f3_op = AluXor;
      3'b101:  f3_op = alt ? AluSra : AluSrl;
      3'b110:  f3_op = AluOr;
      default: f3_op = AluAnd;
    endcase
  endfunction

  logic [31:0] pc_q, pc_d, pc_plus4, target;
  logic [31:0] instr, rs1_data, rs2_data;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic [31:0] alu_a, alu_b, alu_res, wb_data, load_data;
  logic [ImemAw-1:0] imem_idx;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  alu_op_e     alu_op;
  a_sel_e      a_sel;
  wb_sel_e     wb_sel;
  pc_sel_e     pc_sel;
  logic        b_imm, rf_we, dmem_we, br_taken, redirect;

  assign imem_idx = ImemAw'({2'b00, pc_q[31:2]} % IMEM_WORDS);

  rv32i_imem #(
    .Words (IMEM_WORDS),
    .Aw    (ImemAw)
  ) instr_mem (
    .addr_i  (imem_idx),
    .rdata_o (instr)
  );

  rv32i_regfile reg_file (
    .clk_i     (clk),
    .rst_ni    (reset),
    .raddr_a_i (instr[19:15]),
    .rdata_a_o (rs1_data),
    .raddr_b_i (instr[24:20]),
    .rdata_b_o (rs2_data),
    .we_i      (rf_we),
    .waddr_i   (instr[11:7]),
    .wdata_i   (wb_data)
  );

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Anything not matched below leaves every write disabled and pc_sel at PcSeq.
  always_comb begin
    alu_op  = AluAdd;
    a_sel   = ASelRs1;
    b_imm   = 1'b0;
    imm     = imm_i;
    wb_sel  = WbAlu;
    rf_we   = 1'b0;
    pc_sel  = PcSeq;
    dmem_we = 1'b0;
    case (opcode)
      OpLui: begin
        a_sel = ASelZero;
        b_imm = 1'b1;
        imm   = imm_u;
        rf_we = 1'b1;
      end
      OpAuipc: begin
        a_sel = ASelPc;
        b_imm = 1'b1;
        imm   = imm_u;
        rf_we = 1'b1;
      end
      OpJal: begin
        wb_sel = WbPc4;
        rf_we  = 1'b1;
        pc_sel = PcJal;
      end
      OpJalr: begin
        if (funct3 == 3'b000) begin
          b_imm  = 1'b1;
          wb_sel = WbPc4;
          rf_we  = 1'b1;
          pc_sel = PcJalr;
        end
      end
      OpBranch: begin
        if ((funct3 != 3'b010) && (funct3 != 3'b011)) begin
          pc_sel = PcBranch;
        end
      end
      OpImm: begin
        b_imm  = 1'b1;
        alu_op = f3_op(funct3, (funct3 == 3'b101) && funct7[5]);
        case (funct3)
          3'b001:  rf_we = (funct7 == 7'b0000000);
          3'b101:  rf_we = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: rf_we = 1'b1;
        endcase
      end
      OpReg: begin
        alu_op = f3_op(funct3, funct7[5]);
        rf_we  = (funct7 == 7'b0000000) ||
                 ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
`ifdef CPU_DMEM_EN
      OpLoad: begin
        if (funct3 == 3'b010) begin
          b_imm  = 1'b1;
          wb_sel = WbLoad;
          rf_we  = 1'b1;
        end
      end
      OpStore: begin
        if (funct3 == 3'b010) begin
          b_imm   = 1'b1;
          imm     = imm_s;
          dmem_we = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (a_sel)
      ASelPc:   alu_a = pc_q;
      ASelZero: alu_a = '0;
      default:  alu_a = rs1_data;
    endcase
    alu_b = b_imm ? imm : rs2_data;
    case (alu_op)
      AluSub:  alu_res = alu_a - alu_b;
      AluAnd:  alu_res = alu_a & alu_b;
      AluOr:   alu_res = alu_a | alu_b;
      AluXor:  alu_res = alu_a ^ alu_b;
      AluSll:  alu_res = alu_a << alu_b[4:0];
      AluSrl:  alu_res = alu_a >> alu_b[4:0];
      AluSra:  alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      AluSlt:  alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      AluSltu: alu_res = {31'b0, alu_a < alu_b};
      default: alu_res = alu_a + alu_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_data == rs2_data);
      3'b001:  br_taken = (rs1_data != rs2_data);
      3'b100:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_taken = (rs1_data < rs2_data);
      3'b111:  br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    target   = pc_q + imm_b;
    redirect = 1'b0;
    case (pc_sel)
      PcBranch: redirect = br_taken;
      PcJal: begin
        target   = pc_q + imm_j;
        redirect = 1'b1;
      end
      PcJalr: begin
        target   = alu_res;
        redirect = 1'b1;
      end
      default: ;
    endcase
    pc_d = redirect ? {target[31:2], 2'b00} : pc_plus4;
    case (wb_sel)
      WbPc4:   wb_data = pc_plus4;
      WbLoad:  wb_data = load_data;
      default: wb_data = alu_res;
    endcase
  end

`ifdef CPU_DMEM_EN
  localparam int unsigned DmemAw = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  logic [DmemAw-1:0] dmem_idx;

  assign dmem_idx = DmemAw'({2'b00, alu_res[31:2]} % DMEM_WORDS);

  // Stores are suppressed while reset is held so an abandoned SW leaves memory untouched.
  rv32i_dmem #(
    .Words (DMEM_WORDS),
    .Aw    (DmemAw)
  ) data_mem (
    .clk_i   (clk),
    .we_i    (dmem_we & reset),
    .addr_i  (dmem_idx),
    .wdata_i (rs2_data),
    .rdata_o (load_data)
  );
`else
  logic unused_dmem;
  assign load_data   = '0;
  assign unused_dmem = ^{imm_s, dmem_we, DMEM_WORDS};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end
endmodule

// File: tb/tb_rv32i_cpu.sv
// Directed program bench for rv32i_cpu: table of programs with expected register values,
// plus hand-written sequences for reset behaviour and first-edge timing.

module tb_rv32i_cpu;
  localparam logic [31:0] Nop = 32'h00000013;
  localparam int NV = 7;

  typedef struct {
    string       name;
    int unsigned cycles;
  } vec_t;

  typedef struct {
    int unsigned vec;
    int unsigned rd;
    logic [31:0] exp;
  } chk_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] prog [NV][8];
  vec_t        vecs [NV];
  chk_t        chks [$];

  rv32i_cpu cpu (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add_chk(input int unsigned v, input int unsigned rd, input logic [31:0] exp);
    chk_t c;
    c.vec = v;
    c.rd  = rd;
    c.exp = exp;
    chks.push_back(c);
  endtask

  task automatic set_vec(input int unsigned v, input string name);
    vecs[v].name   = name;
    vecs[v].cycles = 10;
  endtask

  task automatic load(input int unsigned v);
    for (int w = 0; w < 256; w++) cpu.instr_mem.mem[w] = Nop;
    for (int k = 0; k < 8; k++) cpu.instr_mem.mem[k] = prog[v][k];
  endtask

  initial begin
    logic [31:0] x7_exp;
`ifdef CPU_DMEM_EN
    x7_exp = 32'h12345000;
`else
    x7_exp = 32'h0;
`endif

    set_vec(0, "add3");
    prog[0] = '{32'h00100093, 32'h00200113, 32'h002081b3, Nop, Nop, Nop, Nop, Nop};
    add_chk(0, 1, 32'd1); add_chk(0, 2, 32'd2); add_chk(0, 3, 32'd3);

    set_vec(1, "shift");
    prog[1] = '{32'hFFF00093, 32'h0040D113, 32'h4040D193, 32'h00103233, Nop, Nop, Nop, Nop};
    add_chk(1, 1, 32'hFFFFFFFF); add_chk(1, 2, 32'h0FFFFFFF);
    add_chk(1, 3, 32'hFFFFFFFF); add_chk(1, 4, 32'h1);

    set_vec(2, "x0");
    prog[2] = '{32'h00900293, 32'h00500013, 32'h000002B3, Nop, Nop, Nop, Nop, Nop};
    add_chk(2, 0, 32'h0); add_chk(2, 5, 32'h0);

    set_vec(3, "branch");
    prog[3] = '{32'h00300093, 32'h00009463, 32'h00900113, 32'h0080036F,
                32'h00100413, 32'h00700493, Nop, Nop};
    add_chk(3, 1, 32'h3); add_chk(3, 2, 32'h0); add_chk(3, 6, 32'h10);
    add_chk(3, 8, 32'h0); add_chk(3, 9, 32'h7);

    set_vec(4, "dmem");
    prog[4] = '{32'h123450B7, 32'h00102423, 32'h00802383, Nop, Nop, Nop, Nop, Nop};
    add_chk(4, 1, 32'h12345000); add_chk(4, 7, x7_exp);

    set_vec(5, "alu");
    prog[5] = '{32'hFF800093, 32'h00500113, 32'h401101B3, 32'h0020A233,
                32'h0020B2B3, 32'h0020C333, 32'h002113B3, 32'h00001417};
    add_chk(5, 3, 32'hD); add_chk(5, 4, 32'h1); add_chk(5, 5, 32'h0);
    add_chk(5, 6, 32'hFFFFFFFD); add_chk(5, 7, 32'hA0); add_chk(5, 8, 32'h101C);

    set_vec(6, "jalr");
    prog[6] = '{32'hFFF00093, 32'h00106463, 32'h00100113, 32'h0000D463,
                32'h01B00193, 32'h00318267, 32'h00100293, 32'h00200313};
    add_chk(6, 2, 32'h0); add_chk(6, 3, 32'h1B); add_chk(6, 4, 32'h18);
    add_chk(6, 5, 32'h0); add_chk(6, 6, 32'h2);

    // Reset state: every register reads zero while reset is held.
    #2 reset = 1'b0;
    load(0);
    @(negedge clk);
    for (int r = 0; r < 32; r++) begin
      check($sformatf("reset x%0d", r), cpu.reg_file.regs[r], 32'h0);
    end

    for (int v = 0; v < NV; v++) begin
      reset = 1'b0;
      load(v);
      @(negedge clk);
      reset = 1'b1;
      repeat (vecs[v].cycles) @(negedge clk);
      foreach (chks[c]) begin
        if (chks[c].vec == v) begin
          check($sformatf("%s x%0d", vecs[v].name, chks[c].rd),
                cpu.reg_file.regs[chks[c].rd], chks[c].exp);
        end
      end
    end

    // First edge after release retires mem[0] only; then reset mid-run and restart.
    reset = 1'b0;
    load(0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("first edge x1", cpu.reg_file.regs[1], 32'd1);
    check("first edge x2", cpu.reg_file.regs[2], 32'd0);
    @(negedge clk);
    check("second edge x2", cpu.reg_file.regs[2], 32'd2);
    #2 reset = 1'b0;
    #1;
    check("async clear x1", cpu.reg_file.regs[1], 32'd0);
    check("async clear x2", cpu.reg_file.regs[2], 32'd0);
    @(negedge clk);
    check("held clear x1", cpu.reg_file.regs[1], 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("restart x1", cpu.reg_file.regs[1], 32'd1);
    check("restart x2", cpu.reg_file.regs[2], 32'd0);
    repeat (8) @(negedge clk);
    check("restart x2 final", cpu.reg_file.regs[2], 32'd2);
    check("restart x3 final", cpu.reg_file.regs[3], 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
